// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce FSM states, frame-result codes, code-width helper.
// Ports: none (package only).
// Optional feature macro used by the scanner: KEYPAD_REPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        KP_IDLE     = 2'd0,
        KP_PRESS_DB = 2'd1,
        KP_HELD     = 2'd2,
        KP_REL_DB   = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_res_e;

    // Bits needed for a key code row*COLS+col; never narrower than one bit.
    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 2) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Registered synchronous event FIFO; head word visible combinationally from storage, 0 after reset.
// Ports: clk, rst (async active-low), push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o.
// A push while full is accepted only when a pop happens in the same cycle; otherwise it is ignored.
module keypad_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en, rd_en;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign wr_en      = push_i && (!full_o || pop_i);
    assign rd_en      = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-cold row drive, per-frame debounce FSM, key-press events queued in a FIFO.
// Ports: clk, rst (async active-low), keypadcol (active-low sense), keypadrow (one-cold drive),
//        key_code/key_valid/key_ready (event pop handshake), key_held, overflow (sticky drop flag).
// Optional macro KEYPAD_REPEAT_EN: auto-repeat pushes while a key stays held.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 100,
    parameter int DEBOUNCE     = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    localparam int CW          = code_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] keypadcol,
    output logic [ROWS-1:0] keypadrow,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = (COLS > 2) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       hits_q, hits_d, row_hits;
    logic [CW-1:0]    acc_code_q, acc_code_d, row_code, frame_code;
    logic [COL_W-1:0] row_col;
    logic [2:0]       hit_sum;
    logic             sample, frame_end;
    frame_res_e       fr;

    kp_state_e        state_q, state_d;
    logic [CW-1:0]    cand_q, cand_d, push_dat;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop, fifo_full, fifo_empty, ovf_q;

    // Row dwell: columns are sampled on the last dwell cycle, the row advances on that same edge.
    assign sample    = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = sample && (row_q == ROW_W'(ROWS - 1));
    assign keypadrow = ~(ROWS'(1) << row_q);

    always_comb begin
        div_d = sample ? '0 : div_q + 1'b1;
        row_d = row_q;
        if (sample) row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end

    // Low bits in the active row: count saturates at 2, lowest index kept as the candidate column.
    always_comb begin
        row_hits = 2'd0;
        row_col  = '0;
        for (int j = COLS - 1; j >= 0; j--)
            if (!keypadcol[j]) row_col = COL_W'(j);
        for (int j = 0; j < COLS; j++)
            if (!keypadcol[j] && row_hits != 2'd2) row_hits = row_hits + 2'd1;
    end

    // Frame accumulation; the final row's sample is folded in combinationally at frame end.
    always_comb begin
        row_code   = CW'(int'(row_q) * COLS + int'(row_col));
        hit_sum    = {1'b0, hits_q} + {1'b0, row_hits};
        frame_code = (hits_q == 2'd0) ? row_code : acc_code_q;
        if (hit_sum == 3'd0)      fr = FR_NONE;
        else if (hit_sum == 3'd1) fr = FR_ONE;
        else                      fr = FR_MULTI;
        hits_d     = hits_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            hits_d     = '0;
            acc_code_d = '0;
        end else if (sample) begin
            hits_d     = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
            acc_code_d = frame_code;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] rep_q, rep_d, rep_nxt;
    logic             rep_ph_q, rep_ph_d;
`endif

    // Debounce FSM, stepped only at frame end.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        push_dat = cand_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d    = rep_q;
        rep_ph_d = rep_ph_q;
        rep_nxt  = rep_q + 1'b1;
`endif
        if (frame_end) begin
            case (state_q)
                KP_IDLE: begin
                    if (fr == FR_ONE) begin
                        cand_d   = frame_code;
                        push_dat = frame_code;
                        if (DEBOUNCE == 1) begin
                            state_d = KP_HELD;
                            push    = 1'b1;
                        end else begin
                            state_d = KP_PRESS_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                KP_PRESS_DB: begin
                    if (fr == FR_ONE && frame_code == cand_q) begin
                        if (int'(cnt_q) + 1 >= DEBOUNCE) begin
                            state_d = KP_HELD;
                            cnt_d   = '0;
                            push    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (fr == FR_ONE) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = KP_IDLE;
                        cnt_d   = '0;
                    end
                end
                KP_HELD: begin
                    if (fr == FR_NONE) begin
                        if (DEBOUNCE == 1) begin
                            state_d = KP_IDLE;
                        end else begin
                            state_d = KP_REL_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_ph_q ? (int'(rep_nxt) == REPEAT_RATE)
                                      : (int'(rep_nxt) == REPEAT_DELAY)) begin
                        push     = 1'b1;
                        rep_d    = '0;
                        rep_ph_d = 1'b1;
                    end else begin
                        rep_d = rep_nxt;
                    end
`endif
                end
                default: begin // KP_REL_DB
                    if (fr == FR_NONE) begin
                        if (int'(cnt_q) + 1 >= DEBOUNCE) begin
                            state_d = KP_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = KP_HELD;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat timing survives a release bounce; it restarts only once the key is really gone.
        if (state_d == KP_IDLE || state_d == KP_PRESS_DB) begin
            rep_d    = '0;
            rep_ph_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= '0;
            row_q      <= '0;
            hits_q     <= '0;
            acc_code_q <= '0;
            state_q    <= KP_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            row_q      <= row_d;
            hits_q     <= hits_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q    <= '0;
            rep_ph_q <= 1'b0;
        end else begin
            rep_q    <= rep_d;
            rep_ph_q <= rep_ph_d;
        end
    end
`endif

    assign pop       = key_valid && key_ready;
    assign key_valid = !fifo_empty;
    assign key_held  = (state_q == KP_HELD) || (state_q == KP_REL_DB);
    assign overflow  = ovf_q;

    keypad_evt_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (key_code),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: 4x4 keypad, 4-cycle dwell, 2-frame debounce, 4-entry FIFO.
// A behavioural key matrix pulls column lines low for pressed keys in the driven row.
module tb_keypad_scan_ctrl;

    logic        clk, rst, key_ready, key_valid, key_held, overflow;
    logic [3:0]  keypadcol, keypadrow, key_code;
    logic [15:0] keys;
    int          cyc, nvec, nmis;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        bit          pop;
        logic        exp_valid;
        logic [3:0]  exp_code;
        bit          chk_code;
        logic        exp_held;
        logic        exp_ovf;
    } vec_t;

    vec_t       vt [16];
    logic [3:0] ocodes [5];
    logic [8:0] rep_exp;

    keypad_scan_ctrl #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4),
        .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keypadcol (keypadcol),
        .keypadrow (keypadrow),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset release; frame ends fall on multiples of 16.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always_comb begin
        keypadcol = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!keypadrow[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4 + c]) keypadcol[c] = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next frame-end edge.
    task automatic to_boundary();
        int guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (cyc % 16 != 0 && guard < 40);
        if (guard >= 40) check("frame_align", 16'(cyc % 16), 16'd0);
    endtask

    initial begin
        nvec = 0; nmis = 0;
        rst = 1'b0; keys = '0; key_ready = 1'b0;
        //        keys      frm pop val code chk held ovf
        vt[0]  = '{16'h0000, 1, 0, 0, 4'd0,  0, 0, 0};
        vt[1]  = '{16'h0200, 1, 0, 0, 4'd0,  0, 0, 0};  // key 9, 1st frame: debouncing
        vt[2]  = '{16'h0200, 1, 0, 1, 4'd9,  1, 1, 0};  // 2nd frame: event queued
        vt[3]  = '{16'h0200, 1, 0, 1, 4'd9,  1, 1, 0};
        vt[4]  = '{16'h0000, 1, 0, 1, 4'd9,  1, 1, 0};  // release debounce
        vt[5]  = '{16'h0000, 1, 0, 1, 4'd9,  1, 0, 0};
        vt[6]  = '{16'h0000, 1, 1, 0, 4'd0,  0, 0, 0};  // one pop empties: single event
        vt[7]  = '{16'h0008, 1, 0, 0, 4'd0,  0, 0, 0};  // one-frame glitch on key 3
        vt[8]  = '{16'h0000, 1, 0, 0, 4'd0,  0, 0, 0};
        vt[9]  = '{16'h0041, 2, 0, 0, 4'd0,  0, 0, 0};  // keys 0 and 6: multi
        vt[10] = '{16'h0000, 1, 0, 0, 4'd0,  0, 0, 0};
        vt[11] = '{16'h0020, 2, 0, 1, 4'd5,  1, 1, 0};  // key 5 accepted
        vt[12] = '{16'h0000, 1, 0, 1, 4'd5,  1, 1, 0};  // one-frame drop
        vt[13] = '{16'h0020, 2, 0, 1, 4'd5,  1, 1, 0};  // back to held
        vt[14] = '{16'h0000, 2, 0, 1, 4'd5,  1, 0, 0};
        vt[15] = '{16'h0000, 1, 1, 0, 4'd0,  0, 0, 0};  // no second key-5 event
        ocodes = '{4'd1, 4'd4, 4'd11, 4'd14, 4'd15};
`ifdef KEYPAD_REPEAT_EN
        rep_exp = 9'h0A4;   // frames 2, 5, 7
`else
        rep_exp = 9'h004;   // frame 2 only
`endif

        #23;
        check("rst_row",   16'(keypadrow), 16'hE);
        check("rst_valid", 16'(key_valid), 16'd0);
        check("rst_code",  16'(key_code),  16'd0);
        check("rst_held",  16'(key_held),  16'd0);
        check("rst_ovf",   16'(overflow),  16'd0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("row0_dwell", 16'(keypadrow), 16'hE);
        @(posedge clk); #1;
        check("row1_after4", 16'(keypadrow), 16'hD);
        to_boundary();

        for (int i = 0; i < 16; i++) begin
            keys = vt[i].keys;
            if (vt[i].pop) begin
                key_ready = 1'b1;
                @(posedge clk); #1;
                key_ready = 1'b0;
            end
            for (int f = 0; f < vt[i].frames; f++) to_boundary();
            check($sformatf("vec%0d_valid", i), 16'(key_valid), 16'(vt[i].exp_valid));
            check($sformatf("vec%0d_held", i),  16'(key_held),  16'(vt[i].exp_held));
            check($sformatf("vec%0d_ovf", i),   16'(overflow),  16'(vt[i].exp_ovf));
            if (vt[i].chk_code)
                check($sformatf("vec%0d_code", i), 16'(key_code), 16'(vt[i].exp_code));
        end

        // Five presses with no consumer: fifth is dropped and overflow sticks.
        for (int i = 0; i < 5; i++) begin
            keys = 16'd1 << ocodes[i];
            to_boundary(); to_boundary();
            keys = '0;
            to_boundary(); to_boundary();
            check($sformatf("ovf_after_press%0d", i), 16'(overflow), 16'(i == 4));
        end
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), 16'(key_valid), 16'd1);
            check($sformatf("drain%0d_code", i),  16'(key_code),  16'(ocodes[i]));
            @(posedge clk); #1;
        end
        check("drain_empty", 16'(key_valid), 16'd0);
        check("drain_ovf",   16'(overflow),  16'd1);
        key_ready = 1'b0;

        // Reset mid-scan drops queued events and clears the sticky flag.
        to_boundary();
        keys = 16'h0004;
        to_boundary(); to_boundary();
        check("pre_rst_code", 16'(key_code), 16'd2);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", 16'(key_valid), 16'd0);
        check("midrst_code",  16'(key_code),  16'd0);
        check("midrst_held",  16'(key_held),  16'd0);
        check("midrst_ovf",   16'(overflow),  16'd0);
        check("midrst_row",   16'(keypadrow), 16'hE);
        keys = '0;
        @(negedge clk); rst = 1'b1;
        to_boundary();

        // Long hold of key 7 with a ready consumer: one cycle of valid per push.
        key_ready = 1'b1;
        keys = 16'h0080;
        for (int f = 1; f <= 8; f++) begin
            to_boundary();
            check($sformatf("hold7_frame%0d", f), 16'(key_valid), 16'(rep_exp[f]));
            if (rep_exp[f]) check($sformatf("hold7_code%0d", f), 16'(key_code), 16'd7);
        end
        keys = '0;
        to_boundary(); to_boundary();
        check("hold7_released", 16'(key_held),  16'd0);
        check("hold7_empty",    16'(key_valid), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
